// File: rtl/axi_pkg.sv
// Shared AXI read-side constants plus the owner and FSM encodings used by
// the read arbiter and the core top.
package axi_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned LEN_W  = 4;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read channel between instruction fetch and data load,
// one outstanding burst at a time, routing R beats back to the owner.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter logic [3:0]  INST_ID = 4'd0,
    parameter logic [3:0]  DATA_ID = 4'd1,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [LEN_W-1:0]  inst_len,
    output logic              inst_addr_ok,
    output logic              inst_rvalid,
    output logic              inst_rlast,

    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LEN_W-1:0]  data_len,
    output logic              data_addr_ok,
    output logic              data_rvalid,
    output logic              data_rlast,

    output logic [DATA_W-1:0] rd_rdata,
    output logic              rd_err,

    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [LEN_W-1:0]  arlen,
    output logic              arvalid,
    input  logic              arready,

    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    owner_e              pick;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic                fwd;

    // Round-robin between the two requesters; on a tie the one not served last wins.
    function automatic owner_e rr_pick(input logic ireq, input logic dreq, input owner_e last);
        if (ireq && dreq) begin
            return (last == OWN_INST) ? OWN_DATA : OWN_INST;
        end else if (dreq) begin
            return OWN_DATA;
        end
        return OWN_INST;
    endfunction

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            owner_q <= OWN_INST;
            last_q  <= OWN_INST;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_d       = last_q;
        id_d         = id_q;
        addr_d       = addr_q;
        len_d        = len_q;
        pick         = OWN_INST;
        fwd          = 1'b0;
        inst_addr_ok = 1'b0;
        inst_rvalid  = 1'b0;
        inst_rlast   = 1'b0;
        data_addr_ok = 1'b0;
        data_rvalid  = 1'b0;
        data_rlast   = 1'b0;
        rd_rdata     = '0;
        rd_err       = 1'b0;
        arid         = '0;
        araddr       = '0;
        arlen        = '0;
        arvalid      = 1'b0;
        rready       = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    pick    = rr_pick(inst_req, data_req, last_q);
                    owner_d = pick;
                    last_d  = pick;
                    id_d    = (pick == OWN_DATA) ? DATA_ID : INST_ID;
                    addr_d  = (pick == OWN_DATA) ? data_addr : inst_addr;
                    len_d   = (pick == OWN_DATA) ? data_len : inst_len;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                arid    = id_q;
                araddr  = addr_q;
                arlen   = len_q;
                if (arready) begin
                    inst_addr_ok = (owner_q == OWN_INST);
                    data_addr_ok = (owner_q == OWN_DATA);
                    state_d      = DATA;
                end
            end
            DATA: begin
                rready = 1'b1;
                // Beats carrying a foreign id are drained but never forwarded.
                fwd = rvalid && (rid == id_q);
                if (fwd) begin
                    rd_rdata    = rdata;
                    rd_err      = (rresp != RESP_OKAY);
                    inst_rvalid = (owner_q == OWN_INST);
                    inst_rlast  = (owner_q == OWN_INST) && rlast;
                    data_rvalid = (owner_q == OWN_DATA);
                    data_rlast  = (owner_q == OWN_DATA) && rlast;
                end
                if (rvalid && rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a table of per-cycle input/expected-output
// records plus hand sequences for reset behaviour.
module tb_axi_rd_arbiter;

    typedef struct packed {
        logic        inst_req;
        logic [31:0] inst_addr;
        logic [3:0]  inst_len;
        logic        data_req;
        logic [31:0] data_addr;
        logic [3:0]  data_len;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        logic        rlast;
    } in_t;

    typedef struct packed {
        logic        arvalid;
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [3:0]  arlen;
        logic        inst_addr_ok;
        logic        data_addr_ok;
        logic        rready;
        logic        inst_rvalid;
        logic        inst_rlast;
        logic        data_rvalid;
        logic        data_rlast;
        logic [31:0] rd_rdata;
        logic        rd_err;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    logic aclk;
    logic aresetn;
    in_t  cur;
    out_t got;
    int   n_cmp;
    int   n_bad;
    vec_t tbl[$];

    logic        inst_addr_ok, inst_rvalid, inst_rlast;
    logic        data_addr_ok, data_rvalid, data_rlast;
    logic [31:0] rd_rdata;
    logic        rd_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        rready;

    axi_rd_arbiter #(.INST_ID(4'd0), .DATA_ID(4'd1), .ADDR_W(32)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_req     (cur.inst_req),
        .inst_addr    (cur.inst_addr),
        .inst_len     (cur.inst_len),
        .inst_addr_ok (inst_addr_ok),
        .inst_rvalid  (inst_rvalid),
        .inst_rlast   (inst_rlast),
        .data_req     (cur.data_req),
        .data_addr    (cur.data_addr),
        .data_len     (cur.data_len),
        .data_addr_ok (data_addr_ok),
        .data_rvalid  (data_rvalid),
        .data_rlast   (data_rlast),
        .rd_rdata     (rd_rdata),
        .rd_err       (rd_err),
        .arid         (arid),
        .araddr       (araddr),
        .arlen        (arlen),
        .arvalid      (arvalid),
        .arready      (cur.arready),
        .rid          (cur.rid),
        .rdata        (cur.rdata),
        .rresp        (cur.rresp),
        .rlast        (cur.rlast),
        .rvalid       (cur.rvalid),
        .rready       (rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic in_t mk_in(logic ir, logic [31:0] ia, logic [3:0] il,
                                  logic dr, logic [31:0] da, logic [3:0] dl, logic ard,
                                  logic rv, logic [3:0] id, logic [31:0] rd, logic [1:0] rr, logic rl);
        in_t r;
        r = '{inst_req: ir, inst_addr: ia, inst_len: il, data_req: dr, data_addr: da,
              data_len: dl, arready: ard, rvalid: rv, rid: id, rdata: rd, rresp: rr, rlast: rl};
        return r;
    endfunction

    function automatic out_t mk_out(logic av, logic [3:0] id, logic [31:0] a, logic [3:0] len,
                                    logic iok, logic dok, logic rdy, logic iv, logic il,
                                    logic dv, logic dl, logic [31:0] d, logic e);
        out_t r;
        r = '{arvalid: av, arid: id, araddr: a, arlen: len, inst_addr_ok: iok, data_addr_ok: dok,
              rready: rdy, inst_rvalid: iv, inst_rlast: il, data_rvalid: dv, data_rlast: dl,
              rd_rdata: d, rd_err: e};
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r = '{arvalid: arvalid, arid: arid, araddr: araddr, arlen: arlen,
              inst_addr_ok: inst_addr_ok, data_addr_ok: data_addr_ok, rready: rready,
              inst_rvalid: inst_rvalid, inst_rlast: inst_rlast, data_rvalid: data_rvalid,
              data_rlast: data_rlast, rd_rdata: rd_rdata, rd_err: rd_err};
        return r;
    endfunction

    task automatic compare(input string name, input out_t exp);
        got = sample();
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge and check the settled outputs.
    task automatic step(input string name, input in_t i, input out_t exp);
        @(negedge aclk);
        cur = i;
        #1;
        compare(name, exp);
    endtask

    task automatic add(input string name, input in_t i, input out_t o);
        vec_t v;
        v.name = name;
        v.i    = i;
        v.o    = o;
        tbl.push_back(v);
    endtask

    in_t  z_in;
    out_t z_out;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        z_in    = '0;
        z_out   = '0;
        cur     = '0;
        aresetn = 1'b0;

        // Single fetch, arready after two wait cycles
        add("t1_idle",   mk_in(1,32'hBFC00000,0, 0,0,0, 0, 0,0,0,0,0), z_out);
        add("t1_addr0",  mk_in(1,32'hBFC00000,0, 0,0,0, 0, 0,0,0,0,0), mk_out(1,0,32'hBFC00000,0, 0,0, 0,0,0,0,0,0,0));
        add("t1_addr1",  mk_in(1,32'hBFC00000,0, 0,0,0, 0, 0,0,0,0,0), mk_out(1,0,32'hBFC00000,0, 0,0, 0,0,0,0,0,0,0));
        add("t1_addrok", mk_in(1,32'hBFC00000,0, 0,0,0, 1, 0,0,0,0,0), mk_out(1,0,32'hBFC00000,0, 1,0, 0,0,0,0,0,0,0));
        add("t1_wait",   mk_in(0,0,0, 0,0,0, 0, 0,0,0,0,0),            mk_out(0,0,0,0, 0,0, 1,0,0,0,0,0,0));
        add("t1_beat",   mk_in(0,0,0, 0,0,0, 0, 1,0,32'h3C1D0000,0,1), mk_out(0,0,0,0, 0,0, 1,1,1,0,0,32'h3C1D0000,0));
        add("t1_idle2",  z_in, z_out);
        // Round-robin ties; a request rising with rlast waits for IDLE
        add("t2_tie1",   mk_in(1,32'h100,0, 1,32'h200,0, 0, 0,0,0,0,0), z_out);
        add("t2_addr1",  mk_in(1,32'h100,0, 1,32'h200,0, 1, 0,0,0,0,0), mk_out(1,1,32'h200,0, 0,1, 0,0,0,0,0,0,0));
        add("t2_beat1",  mk_in(1,32'h100,0, 0,0,0, 0, 1,1,32'h11111111,0,1), mk_out(0,0,0,0, 0,0, 1,0,0,1,1,32'h11111111,0));
        add("t2_dead",   mk_in(1,32'h100,0, 0,0,0, 0, 0,0,0,0,0), z_out);
        add("t2_addr2",  mk_in(1,32'h100,0, 0,0,0, 1, 0,0,0,0,0), mk_out(1,0,32'h100,0, 1,0, 0,0,0,0,0,0,0));
        add("t2_beat2",  mk_in(1,32'h300,0, 1,32'h400,0, 0, 1,0,32'h22222222,0,1), mk_out(0,0,0,0, 0,0, 1,1,1,0,0,32'h22222222,0));
        add("t2_tie3",   mk_in(1,32'h300,0, 1,32'h400,0, 0, 0,0,0,0,0), z_out);
        add("t2_addr3",  mk_in(1,32'h300,0, 1,32'h400,0, 1, 0,0,0,0,0), mk_out(1,1,32'h400,0, 0,1, 0,0,0,0,0,0,0));
        add("t2_beat3",  mk_in(0,0,0, 0,0,0, 0, 1,1,32'h33333333,0,1), mk_out(0,0,0,0, 0,0, 1,0,0,1,1,32'h33333333,0));
        // Four-beat load with gaps, error on second beat, stray-id beat in a gap
        add("t3_idle",   mk_in(0,0,0, 1,32'h1000,3, 0, 0,0,0,0,0), z_out);
        add("t3_addr",   mk_in(0,0,0, 1,32'h1000,3, 1, 0,0,0,0,0), mk_out(1,1,32'h1000,3, 0,1, 0,0,0,0,0,0,0));
        add("t3_b0",     mk_in(0,0,0, 0,0,0, 0, 1,1,32'hA0,0,0), mk_out(0,0,0,0, 0,0, 1,0,0,1,0,32'hA0,0));
        add("t3_b1_err", mk_in(0,0,0, 0,0,0, 0, 1,1,32'hA1,2'b10,0), mk_out(0,0,0,0, 0,0, 1,0,0,1,0,32'hA1,1));
        add("t3_stray",  mk_in(0,0,0, 0,0,0, 0, 1,0,32'hDEAD,0,0), mk_out(0,0,0,0, 0,0, 1,0,0,0,0,0,0));
        add("t3_gap",    mk_in(0,0,0, 0,0,0, 0, 0,0,0,0,0), mk_out(0,0,0,0, 0,0, 1,0,0,0,0,0,0));
        add("t3_b2",     mk_in(0,0,0, 0,0,0, 0, 1,1,32'hA2,0,0), mk_out(0,0,0,0, 0,0, 1,0,0,1,0,32'hA2,0));
        add("t3_gap2",   mk_in(1,32'h50,0, 0,0,0, 0, 0,0,0,0,0), mk_out(0,0,0,0, 0,0, 1,0,0,0,0,0,0));
        add("t3_b3",     mk_in(1,32'h50,0, 0,0,0, 0, 1,1,32'hA3,0,1), mk_out(0,0,0,0, 0,0, 1,0,0,1,1,32'hA3,0));
        // Fetch drops its request before any grant while a load rises
        add("t6_idle",   mk_in(0,0,0, 1,32'h2000,0, 0, 0,0,0,0,0), z_out);
        add("t6_addr",   mk_in(0,0,0, 1,32'h2000,0, 1, 0,0,0,0,0), mk_out(1,1,32'h2000,0, 0,1, 0,0,0,0,0,0,0));
        add("t6_beat",   mk_in(0,0,0, 0,0,0, 0, 1,1,32'h44,0,1), mk_out(0,0,0,0, 0,0, 1,0,0,1,1,32'h44,0));
        add("t6_idle2",  z_in, z_out);

        repeat (2) @(negedge aclk);
        cur = mk_in(1,32'h77,0, 1,32'h88,0, 1, 1,0,32'hFFFF,2'b11,1);
        #1;
        compare("reset_state", z_out);
        @(negedge aclk);
        cur     = '0;
        aresetn = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].name, tbl[k].i, tbl[k].o);
        end

        // Asynchronous reset in the middle of a four-beat fetch
        step("t5_idle",  mk_in(1,32'h5000,3, 0,0,0, 0, 0,0,0,0,0), z_out);
        step("t5_addr",  mk_in(1,32'h5000,3, 0,0,0, 1, 0,0,0,0,0), mk_out(1,0,32'h5000,3, 1,0, 0,0,0,0,0,0,0));
        step("t5_b0",    mk_in(0,0,0, 0,0,0, 0, 1,0,32'hB0,0,0), mk_out(0,0,0,0, 0,0, 1,1,0,0,0,32'hB0,0));
        step("t5_b1",    mk_in(0,0,0, 0,0,0, 0, 1,0,32'hB1,0,0), mk_out(0,0,0,0, 0,0, 1,1,0,0,0,32'hB1,0));
        #2;
        aresetn = 1'b0;
        #1;
        compare("t5_async_rst", z_out);
        @(negedge aclk);
        cur     = '0;
        aresetn = 1'b1;
        step("t5_post_idle", mk_in(1,32'h6000,0, 0,0,0, 0, 0,0,0,0,0), z_out);
        step("t5_post_addr", mk_in(1,32'h6000,0, 0,0,0, 1, 0,0,0,0,0), mk_out(1,0,32'h6000,0, 1,0, 0,0,0,0,0,0,0));
        step("t5_post_beat", mk_in(0,0,0, 0,0,0, 0, 1,0,32'hC0,0,1), mk_out(0,0,0,0, 0,0, 1,1,1,0,0,32'hC0,0));
        step("t5_post_end",  z_in, z_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
